// File: rtl/uart_cmd_pkg.sv
// Shared constants, command codes and state enums for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] KEY_BYTE  = 8'h11;

  localparam logic [7:0] CMD_SEG0  = 8'h10;
  localparam logic [7:0] CMD_LED   = 8'h20;
  localparam logic [7:0] CMD_READ  = 8'h30;
  localparam logic [7:0] CMD_PING  = 8'h40;

  typedef enum logic [1:0] {R_IDLE, R_CMD, R_ARG, R_CHK} rx_state_e;
  typedef enum logic {T_IDLE, T_GAP} tx_state_e;

  // Segment writes occupy 0x10..0x13; the low two bits pick the register.
  function automatic logic is_seg_cmd(input logic [7:0] cmd);
    return cmd[7:2] == CMD_SEG0[7:2];
  endfunction

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return is_seg_cmd(cmd) || (cmd == CMD_LED) || (cmd == CMD_READ) || (cmd == CMD_PING);
  endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Paces bytes into the UART transmitter so consecutive sends are at least one frame apart.
module uart_tx_pacer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4340
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       ready,
  output logic       uart_send,
  output logic [7:0] uart_data_in
);

  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          send_q, send_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;

  // Next-state: accept a push in T_IDLE, then hold off for GAP_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    send_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      T_IDLE: begin
        if (push) begin
          send_d  = 1'b1;
          data_d  = push_data;
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = T_GAP;
        end
      end
      T_GAP: begin
        if (cnt_q == '0) begin
          state_d = T_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
    ready_d = (state_d == T_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      send_q  <= send_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign ready        = ready_q;
  assign uart_send    = send_q;
  assign uart_data_in = data_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 4-byte UART command frames, drives display/LED registers and arbitrates replies and key messages onto the shared transmitter.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TX_GAP_CYCLES = 4340,
  parameter int unsigned RX_TIMEOUT    = 500000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rec,
  input  logic [7:0] uart_data_out,
  input  logic       key_req,
  output logic       uart_send,
  output logic [7:0] uart_data_in,
  output logic [7:0] seg_data0,
  output logic [7:0] seg_data1,
  output logic [7:0] seg_data2,
  output logic [7:0] seg_data3,
  output logic       led,
  output logic [7:0] err_cnt
);

  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);

  rx_state_e       rx_state_q, rx_state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0][7:0] seg_q, seg_d;
  logic            led_q, led_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      buf0_q, buf0_d;
  logic [7:0]      buf1_q, buf1_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  logic            key_pend_q, key_pend_d;

  logic            err_inc;
  logic            tx_ready;
  logic            tx_push;
  logic [7:0]      tx_push_data;

  // Next-state: TX arbitration, key capture, frame parsing, evaluation and timeout.
  always_comb begin
    rx_state_d   = rx_state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    to_cnt_d     = to_cnt_q;
    seg_d        = seg_q;
    led_d        = led_q;
    err_d        = err_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    buf_cnt_d    = buf_cnt_q;
    key_pend_d   = key_pend_q;
    err_inc      = 1'b0;
    tx_push      = 1'b0;
    tx_push_data = buf0_q;

    // Reply bytes win; the buffer stays non-empty until both are out, so a key never splits a reply.
    if (tx_ready) begin
      if (buf_cnt_q != 2'd0) begin
        tx_push      = 1'b1;
        tx_push_data = buf0_q;
        buf0_d       = buf1_q;
        buf_cnt_d    = buf_cnt_q - 2'd1;
      end else if (key_pend_q) begin
        tx_push      = 1'b1;
        tx_push_data = KEY_BYTE;
        key_pend_d   = 1'b0;
      end
    end

    // A press seen while one is still pending (including its serve cycle) is dropped.
    if (key_req && !key_pend_q) begin
      key_pend_d = 1'b1;
    end

    case (rx_state_q)
      R_IDLE: begin
        if (uart_rec && (uart_data_out == SYNC_BYTE)) begin
          rx_state_d = R_CMD;
          to_cnt_d   = '0;
        end
      end
      R_CMD, R_ARG, R_CHK: begin
        if (uart_rec) begin
          to_cnt_d = '0;
          case (rx_state_q)
            R_CMD: begin
              cmd_d      = uart_data_out;
              rx_state_d = R_ARG;
            end
            R_ARG: begin
              arg_d      = uart_data_out;
              rx_state_d = R_CHK;
            end
            default: begin
              rx_state_d = R_IDLE;
              if (buf_cnt_q != 2'd0) begin
                err_inc = 1'b1;
              end else begin
                buf_cnt_d = 2'd2;
                buf0_d    = ACK_BYTE;
                buf1_d    = arg_q;
                if ((uart_data_out != 8'(cmd_q + arg_q)) || !is_known_cmd(cmd_q)) begin
                  buf0_d  = NAK_BYTE;
                  buf1_d  = cmd_q;
                  err_inc = 1'b1;
                end else if (is_seg_cmd(cmd_q)) begin
                  seg_d[cmd_q[1:0]] = arg_q;
                end else if (cmd_q == CMD_LED) begin
                  led_d = arg_q[0];
                end else if (cmd_q == CMD_READ) begin
                  buf1_d = seg_q[arg_q[1:0]];
                end
              end
            end
          endcase
        end else if (to_cnt_q == TW'(RX_TIMEOUT - 1)) begin
          rx_state_d = R_IDLE;
          to_cnt_d   = '0;
          err_inc    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
    endcase

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // State and resource registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_state_q <= R_IDLE;
      cmd_q      <= 8'h00;
      arg_q      <= 8'h00;
      to_cnt_q   <= '0;
      seg_q      <= '0;
      led_q      <= 1'b0;
      err_q      <= 8'h00;
      buf0_q     <= 8'h00;
      buf1_q     <= 8'h00;
      buf_cnt_q  <= 2'd0;
      key_pend_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      to_cnt_q   <= to_cnt_d;
      seg_q      <= seg_d;
      led_q      <= led_d;
      err_q      <= err_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      buf_cnt_q  <= buf_cnt_d;
      key_pend_q <= key_pend_d;
    end
  end

  uart_tx_pacer #(
    .GAP_CYCLES (TX_GAP_CYCLES)
  ) u_pacer (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .push         (tx_push),
    .push_data    (tx_push_data),
    .ready        (tx_ready),
    .uart_send    (uart_send),
    .uart_data_in (uart_data_in)
  );

  assign seg_data0 = seg_q[0];
  assign seg_data1 = seg_q[1];
  assign seg_data2 = seg_q[2];
  assign seg_data3 = seg_q[3];
  assign led       = led_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected TX bytes, a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;

  localparam int GAP = 20;
  localparam int TMO = 300;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rec = 1'b0;
  logic [7:0] uart_data_out = 8'h00;
  logic       key_req = 1'b0;
  logic       uart_send;
  logic [7:0] uart_data_in;
  logic [7:0] seg_data0, seg_data1, seg_data2, seg_data3;
  logic       led;
  logic [7:0] err_cnt;

  uart_cmd_ctrl #(
    .TX_GAP_CYCLES (GAP),
    .RX_TIMEOUT    (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .uart_rec      (uart_rec),
    .uart_data_out (uart_data_out),
    .key_req       (key_req),
    .uart_send     (uart_send),
    .uart_data_in  (uart_data_in),
    .seg_data0     (seg_data0),
    .seg_data1     (seg_data1),
    .seg_data2     (seg_data2),
    .seg_data3     (seg_data3),
    .led           (led),
    .err_cnt       (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] b;
    logic       btb;   // must follow the previous send by exactly GAP+1 cycles
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         have_last = 1'b0;

  logic [7:0] m_seg [4];
  logic       m_led;
  logic [7:0] m_err;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every send must match the head of the scoreboard and respect pacing.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      have_last = 1'b0;
    end else if (uart_send) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_send: got byte %0h, expected no send (cycle %0d)", uart_data_in, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_byte", 32'(uart_data_in), 32'(mon_e.b));
        if (have_last) begin
          if (mon_e.btb) chk("tx_spacing", 32'(cyc - last_cyc), 32'(GAP + 1));
          else           chk("tx_min_gap", 32'((cyc - last_cyc) >= (GAP + 1)), 32'd1);
        end
      end
      last_cyc  = cyc;
      have_last = 1'b1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic btb);
    exp_t e;
    e.b   = b;
    e.btb = btb;
    exp_q.push_back(e);
  endtask

  task automatic model_err();
    if (m_err < 8'd255) m_err = m_err + 8'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_seg[i] = 8'h00;
    m_led = 1'b0;
    m_err = 8'h00;
    exp_q.delete();
  endtask

  // Reference: what a complete frame should do, from the command table.
  task automatic model_eval(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] c, input bit busy);
    bit known;
    known = (cmd >= 8'h10 && cmd <= 8'h13) || cmd == 8'h20 || cmd == 8'h30 || cmd == 8'h40;
    if (busy) begin
      model_err();
    end else if (c != 8'(cmd + arg) || !known) begin
      push_exp(8'h15, 1'b0);
      push_exp(cmd, 1'b1);
      model_err();
    end else begin
      push_exp(8'h06, 1'b0);
      if (cmd == 8'h30) begin
        push_exp(m_seg[int'(arg) % 4], 1'b1);
      end else begin
        push_exp(arg, 1'b1);
        if (cmd >= 8'h10 && cmd <= 8'h13) m_seg[int'(cmd) - 16] = arg;
        if (cmd == 8'h20) m_led = arg[0];
      end
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit k);
    uart_rec      = 1'b1;
    uart_data_out = b;
    key_req       = k;
    tick();
    uart_rec = 1'b0;
    key_req  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] c,
                            input int sp, input bit key_at_chk, input bit busy);
    rx_byte(8'h55, 1'b0);
    repeat (sp) tick();
    rx_byte(cmd, 1'b0);
    repeat (sp) tick();
    rx_byte(arg, 1'b0);
    repeat (sp) tick();
    rx_byte(c, key_at_chk);
    model_eval(cmd, arg, c, busy);
    if (key_at_chk) push_exp(8'h11, 1'b1);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_seg"}, {seg_data3, seg_data2, seg_data1, seg_data0}, {m_seg[3], m_seg[2], m_seg[1], m_seg[0]});
    chk({tag, "_led"}, 32'(led), 32'(m_led));
    chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
  endtask

  task automatic drain(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 2000) begin
      tick();
      n++;
    end
    if (exp_q.size() > left) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d bytes pending, expected %0d", exp_q.size(), left);
      while (exp_q.size() > left) void'(exp_q.pop_front());
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd, arg, c;
    int sel;
    model_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_seg", {seg_data3, seg_data2, seg_data1, seg_data0}, 32'd0);
    chk("rst_misc", 32'({led, err_cnt, uart_send, uart_data_in}), 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Segment write, write latency and reply latency.
    send_frame(8'h12, 8'hA5, 8'hB7, 1, 1'b0, 1'b0);
    check_regs("seg_write");
    chk("reply_lat_pre", 32'(uart_send), 32'd0);
    tick();
    chk("reply_lat", 32'(uart_send), 32'd1);
    drain(0);

    // LED write, then read-back of seg_data2.
    send_frame(8'h20, 8'h01, 8'h21, 2, 1'b0, 1'b0);
    check_regs("led_write");
    drain(0);
    send_frame(8'h30, 8'h02, 8'h32, 0, 1'b0, 1'b0);
    check_regs("read_back");
    drain(0);

    // Bad checksum.
    send_frame(8'h12, 8'hA5, 8'h00, 1, 1'b0, 1'b0);
    check_regs("bad_chk");
    drain(0);

    // Timeout abort, then a frame whose gaps sit one cycle under the limit.
    rx_byte(8'h55, 1'b0);
    rx_byte(8'h10, 1'b0);
    repeat (TMO + 5) tick();
    model_err();
    check_regs("timeout");
    rx_byte(8'h55, 1'b0);
    rx_byte(8'h13, 1'b0);
    repeat (TMO - 1) tick();
    rx_byte(8'h77, 1'b0);
    rx_byte(8'h8A, 1'b0);
    model_eval(8'h13, 8'h77, 8'h8A, 1'b0);
    check_regs("edge_timeout");
    drain(0);

    // Key with CHK in the same cycle, and a second press during the reply.
    send_frame(8'h40, 8'h3C, 8'h7C, 0, 1'b1, 1'b0);
    repeat (5) tick();
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    drain(0);
    check_regs("key_chk");

    // Lone key press with an idle pacer.
    repeat (GAP + 2) tick();
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    push_exp(8'h11, 1'b0);
    chk("key_lat_pre", 32'(uart_send), 32'd0);
    tick();
    chk("key_lat", 32'(uart_send), 32'd1);
    drain(0);
    repeat (GAP + 2) tick();

    // Frame dropped while a reply is pending, then reset mid-reply.
    send_frame(8'h11, 8'h22, 8'h33, 0, 1'b0, 1'b0);
    send_frame(8'h10, 8'h99, 8'hA9, 1, 1'b0, 1'b1);
    check_regs("dropped");
    drain(1);
    sys_rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("midrst_seg", {seg_data3, seg_data2, seg_data1, seg_data0}, 32'd0);
    chk("midrst_misc", 32'({led, err_cnt, uart_send, uart_data_in}), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3 * (GAP + 1)) tick();
    check_regs("post_rst");

    // Randomized frames against the reference model.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 7);
      if (sel < 4)       cmd = 8'h10 + 8'(sel);
      else if (sel == 4) cmd = 8'h20;
      else if (sel == 5) cmd = 8'h30;
      else if (sel == 6) cmd = 8'h40;
      else               cmd = 8'($urandom);
      arg = 8'($urandom);
      c   = 8'(cmd + arg);
      if ($urandom_range(0, 3) == 0) c = 8'(c + 8'($urandom_range(1, 255)));
      send_frame(cmd, arg, c, $urandom_range(0, 4), 1'b0, 1'b0);
      check_regs("rand");
      drain(0);
      if ($urandom_range(0, 3) == 0) begin
        key_req = 1'b1;
        tick();
        key_req = 1'b0;
        push_exp(8'h11, 1'b0);
        drain(0);
      end
    end

    // Bad frames until err_cnt saturates.
    for (int i = 0; i < 262; i++) begin
      cmd = 8'($urandom);
      arg = 8'($urandom);
      send_frame(cmd, arg, 8'(cmd + arg + 8'd1), 0, 1'b0, 1'b0);
      drain(0);
    end
    check_regs("saturate");

    repeat (GAP + 2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
